core_dbg_apb_master: RTL and testbench
======================================

// Module: core_dbg_apb_master
// PURPOSE
//  Debug-host side APB initiator driving the core's debug APB slave port (dbg_apb_*).
//  Takes one debug register command at a time (write/read, addr, data) from a host agent
//  (JTAG DTM / testbench / SoC debug bus), runs a full APB SETUP/ACCESS transfer, and
//  returns one response (read data, or error on timeout). Single outstanding transaction.
// PARAMETERS
//  APB_ADDR_WIDTH   5   debug register address width (matches core DBG_APB_ADDR_WIDTH)
//  APB_WDATA_WIDTH  32  write data width
//  APB_RDATA_WIDTH  32  read data width
//  TIMEOUT_CYCLES   64  max ACCESS cycles waiting for apb_ready; 0 = no timeout
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous active-high reset
//  cmd_valid    in   1        host command valid
//  cmd_ready    out  1        block can accept command (1 only in IDLE)
//  cmd_wr_rd    in   1        1=write, 0=read
//  cmd_addr     in   AW       debug register address
//  cmd_wdata    in   WW       write data (ignored for reads)
//  rsp_valid    out  1        response valid, held until rsp_ready
//  rsp_ready    in   1        host accepts response
//  rsp_rdata    out  RW       read data; 0 for writes and on error
//  rsp_err      out  1        1 = transfer aborted by timeout
//  apb_addr     out  AW       to slave addr
//  apb_sel      out  1        to slave sel
//  apb_enable   out  1        to slave enable
//  apb_wr_rd    out  1        to slave wr_rd
//  apb_wdata    out  WW       to slave wdata
//  apb_ready    in   1        from slave ready
//  apb_rdata    in   RW       from slave rdata
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-high, named rst. All outputs registered except cmd_ready (= state==IDLE).
//  - Reset values: state IDLE, apb_sel/apb_enable/apb_wr_rd 0, apb_addr/apb_wdata 0,
//    rsp_valid/rsp_err 0, rsp_rdata 0, wait counter 0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_valid&cmd_ready at cycle T latches cmd_* into apb_addr/apb_wr_rd/apb_wdata.
//    T+1 = SETUP: apb_sel=1, apb_enable=0.
//  - T+2 = ACCESS: apb_sel=1, apb_enable=1, wait counter cleared on entry. apb_ready sampled each ACCESS cycle.
//    addr/wr_rd/wdata stable from SETUP through last ACCESS cycle.
//  - ready=1 in ACCESS cycle: next cycle RESP, sel=enable=0, rsp_valid=1, rsp_err=0,
//    rsp_rdata=apb_rdata if read else 0. Zero-wait latency cmd accept -> rsp_valid = 3 cycles.
//  - ready=0 in ACCESS cycle: counter++. If TIMEOUT_CYCLES!=0 and the cycle is the TIMEOUT_CYCLES-th
//    ACCESS cycle, abort: next cycle RESP, sel=enable=0, rsp_err=1, rsp_rdata=0.
//    A ready arriving in that same final cycle wins (normal completion, no error).
//  - Counter width $clog2(TIMEOUT_CYCLES+1), saturating; no wrap-around possible.
//  - RESP: rsp_valid/rsp_rdata/rsp_err held stable while rsp_ready=0; cmd_ready=0.
//    rsp_valid&rsp_ready -> IDLE next cycle, rsp_valid=0. Next cmd accepted earliest in that IDLE cycle,
//    so min 4 cycles per transfer with apb_sel low for at least one cycle between transfers.
//  - apb_addr/apb_wr_rd/apb_wdata keep last value in IDLE/RESP (no glitch to 0).
//  - Reset mid-transfer (any state): next cycle all outputs at reset values. Pending response is dropped,
//    no rsp_valid emitted, and the slave sees sel fall without completion.
//  - Assertions: cmd_addr not X on accept; apb_enable implies apb_sel; rsp_valid&cmd_ready never both 1.
// TESTING
//  1 Write: cmd addr=5'h03 wdata=32'hDEADBEEF at T, apb_ready=1 ->
//    sel=1 T+1..T+2, enable=1 T+2 only, wr_rd=1; rsp_valid T+3, rsp_err=0, rsp_rdata=0.
//  2 Read: addr=5'h1A, slave holds ready=0 for 3 ACCESS cycles then ready=1 with rdata=32'h12345678 ->
//    rsp_valid at T+6, rsp_rdata=32'h12345678, addr stable throughout.
//  3 Timeout: TIMEOUT_CYCLES=4, apb_ready stuck 0 -> sel/enable drop after the 4th ACCESS cycle (T+6),
//    rsp_valid T+6, rsp_err=1, rsp_rdata=0. Variant with ready=1 in the 4th cycle -> rsp_err=0.
//  4 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, cmd_valid=1 meanwhile ->
//    response fields stable, cmd_ready=0, second cmd accepted only the cycle after the handshake.
//  5 Reset: assert rst during ACCESS of a read -> next cycle sel=enable=0, rsp_valid=0;
//    no response for the aborted command ever appears.
//  6 Back-to-back: ITR3 write then DTR read with rsp_ready=1 and cmd_valid held ->
//    2nd accept at T+4, apb_sel low at T+3, both responses correct and in order.

Source files
------------

// File: rtl/core_dbg_apb_master.sv
// Debug-host APB initiator: accepts one register command, runs an APB SETUP/ACCESS
// transfer on the core's debug port, and returns one response (read data or timeout error).
module core_dbg_apb_master #(
  parameter int APB_ADDR_WIDTH  = 5,
  parameter int APB_WDATA_WIDTH = 32,
  parameter int APB_RDATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_wr_rd,
  input  logic [APB_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [APB_WDATA_WIDTH-1:0] cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [APB_RDATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err,
  output logic [APB_ADDR_WIDTH-1:0]  apb_addr,
  output logic                       apb_sel,
  output logic                       apb_enable,
  output logic                       apb_wr_rd,
  output logic [APB_WDATA_WIDTH-1:0] apb_wdata,
  input  logic                       apb_ready,
  input  logic [APB_RDATA_WIDTH-1:0] apb_rdata
);

  // A zero timeout still gets a 1-bit counter so no zero-width vector is ever declared.
  localparam int CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_IDX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(LAST_IDX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           wait_cnt, wait_cnt_nxt;
  logic [APB_ADDR_WIDTH-1:0]  apb_addr_nxt;
  logic                       apb_sel_nxt;
  logic                       apb_enable_nxt;
  logic                       apb_wr_rd_nxt;
  logic [APB_WDATA_WIDTH-1:0] apb_wdata_nxt;
  logic                       rsp_valid_nxt;
  logic [APB_RDATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                       rsp_err_nxt;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      apb_addr   <= '0;
      apb_sel    <= 1'b0;
      apb_enable <= 1'b0;
      apb_wr_rd  <= 1'b0;
      apb_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      apb_addr   <= apb_addr_nxt;
      apb_sel    <= apb_sel_nxt;
      apb_enable <= apb_enable_nxt;
      apb_wr_rd  <= apb_wr_rd_nxt;
      apb_wdata  <= apb_wdata_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
    end
  end

  // Every registered output holds by default, so the address/data bus never glitches.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    apb_addr_nxt   = apb_addr;
    apb_sel_nxt    = apb_sel;
    apb_enable_nxt = apb_enable;
    apb_wr_rd_nxt  = apb_wr_rd;
    apb_wdata_nxt  = apb_wdata;
    rsp_valid_nxt  = rsp_valid;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          apb_addr_nxt   = cmd_addr;
          apb_wr_rd_nxt  = cmd_wr_rd;
          apb_wdata_nxt  = cmd_wdata;
          apb_sel_nxt    = 1'b1;
          apb_enable_nxt = 1'b0;
          state_nxt      = SETUP;
        end
      end

      SETUP: begin
        apb_enable_nxt = 1'b1;
        wait_cnt_nxt   = '0;
        state_nxt      = ACCESS;
      end

      // A ready in the final allowed cycle takes priority over the timeout abort.
      ACCESS: begin
        if (apb_ready) begin
          apb_sel_nxt    = 1'b0;
          apb_enable_nxt = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_err_nxt    = 1'b0;
          rsp_rdata_nxt  = apb_wr_rd ? '0 : apb_rdata;
          state_nxt      = RESP;
        end else if (TIMEOUT_EN && (wait_cnt == LAST_CNT)) begin
          apb_sel_nxt    = 1'b0;
          apb_enable_nxt = 1'b0;
          rsp_valid_nxt  = 1'b1;
          rsp_err_nxt    = 1'b1;
          rsp_rdata_nxt  = '0;
          state_nxt      = RESP;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  a_cmd_addr_known: assert property (@(posedge clk) disable iff (rst)
    (cmd_valid && cmd_ready) |-> !$isunknown(cmd_addr));

  a_enable_needs_sel: assert property (@(posedge clk) disable iff (rst)
    apb_enable |-> apb_sel);

  a_rsp_excludes_cmd: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && cmd_ready));

endmodule

// File: tb/tb_core_dbg_apb_master.sv
// Directed and randomized bench for core_dbg_apb_master; expected timing and data come
// from a transaction-level model (latency = 3 + waits, or timeout after TO ACCESS cycles).
module tb_core_dbg_apb_master;

  localparam int AW = 5;
  localparam int WW = 32;
  localparam int RW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr_rd;
  logic [AW-1:0] cmd_addr;
  logic [WW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] apb_addr;
  logic          apb_sel;
  logic          apb_enable;
  logic          apb_wr_rd;
  logic [WW-1:0] apb_wdata;
  logic          apb_ready;
  logic [RW-1:0] apb_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  core_dbg_apb_master #(
    .APB_ADDR_WIDTH (AW),
    .APB_WDATA_WIDTH(WW),
    .APB_RDATA_WIDTH(RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr_rd (cmd_wr_rd),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb_addr  (apb_addr),
    .apb_sel   (apb_sel),
    .apb_enable(apb_enable),
    .apb_wr_rd (apb_wr_rd),
    .apb_wdata (apb_wdata),
    .apb_ready (apb_ready),
    .apb_rdata (apb_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer: waits = ready-low ACCESS cycles before the slave answers,
  // bp = extra cycles rsp_ready stays low, hold = keep cmd_valid high with junk fields.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                               input int waits, input logic [RW-1:0] rdata, input int bp,
                               input bit hold);
    int lat;
    logic exp_err;
    logic [RW-1:0] exp_rd;
    bit rdy;
    if (waits < TO) begin
      lat    = 3 + waits;
      exp_err = 1'b0;
      exp_rd = wr ? '0 : rdata;
    end else begin
      lat    = 2 + TO;
      exp_err = 1'b1;
      exp_rd = '0;
    end

    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_sel", 32'(apb_sel), 32'd0);
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    apb_ready = 1'b0;
    apb_rdata = $urandom;
    accept_cyc = cyc;

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checkOutput("sel", 32'(apb_sel), 32'(k < lat));
      checkOutput("enable", 32'(apb_enable), 32'((k >= 2) && (k < lat)));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(k == lat));
      checkOutput("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("apb_addr", 32'(apb_addr), 32'(addr));
      checkOutput("apb_wr_rd", 32'(apb_wr_rd), 32'(wr));
      checkOutput("apb_wdata", apb_wdata, wdata);
      if (k == lat) begin
        checkOutput("rsp_rdata", rsp_rdata, exp_rd);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
      cmd_valid = hold;
      if (hold) begin
        cmd_wr_rd = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
      end
      rdy = (k >= 2) && (k < lat) && ((k - 2) == waits);
      apb_ready = rdy;
      apb_rdata = rdy ? rdata : $urandom;
    end

    for (int j = 1; j <= bp; j++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, exp_rd);
      checkOutput("bp_rsp_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_sel", 32'(apb_sel), 32'd0);
      checkOutput("bp_addr", 32'(apb_addr), 32'(addr));
      apb_rdata = $urandom;
      if (hold) begin
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
      end
    end
    rsp_ready = 1'b1;
  endtask

  // Start a read that the slave never answers and reset it in the middle of ACCESS.
  task automatic doResetAbort(input logic [AW-1:0] addr);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rst_pre_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_wr_rd = 1'b0;
    cmd_addr  = addr;
    apb_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    checkOutput("rst_pre_enable", 32'(apb_enable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_sel", 32'(apb_sel), 32'd0);
    checkOutput("rst_enable", 32'(apb_enable), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_addr", 32'(apb_addr), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    apb_ready = 1'b1;
    apb_rdata = $urandom;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
      checkOutput("rst_no_sel", 32'(apb_sel), 32'd0);
    end
    apb_ready = 1'b0;
  endtask

  initial begin
    int first_acc;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr_rd = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    apb_ready = 1'b0;
    apb_rdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_sel", 32'(apb_sel), 32'd0);
    checkOutput("reset_enable", 32'(apb_enable), 32'd0);
    checkOutput("reset_wr_rd", 32'(apb_wr_rd), 32'd0);
    checkOutput("reset_addr", 32'(apb_addr), 32'd0);
    checkOutput("reset_wdata", apb_wdata, 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 5'h03, 32'hDEADBEEF, 0, $urandom, 0, 1'b0);

    $display("[TB] read with three wait cycles");
    applyStimulus(1'b0, 5'h1A, 32'h0, 3, 32'h12345678, 0, 1'b0);

    $display("[TB] timeout with ready stuck low");
    applyStimulus(1'b0, 5'h11, 32'h0, 100, 32'hA5A5A5A5, 0, 1'b0);

    $display("[TB] ready in final allowed cycle");
    applyStimulus(1'b0, 5'h12, 32'h0, TO - 1, 32'h0BADF00D, 0, 1'b0);

    $display("[TB] response backpressure with command held");
    applyStimulus(1'b0, 5'h05, 32'h0, 0, 32'hCAFE0001, 5, 1'b1);
    first_acc = accept_cyc;
    applyStimulus(1'b1, 5'h06, 32'h55AA55AA, 0, $urandom, 0, 1'b0);
    checkOutput("bp_accept_spacing", 32'(accept_cyc - first_acc), 32'd9);

    $display("[TB] reset during ACCESS");
    doResetAbort(5'h1C);

    $display("[TB] back-to-back write then read");
    applyStimulus(1'b1, 5'h0B, 32'h00000013, 0, $urandom, 0, 1'b1);
    first_acc = accept_cyc;
    applyStimulus(1'b0, 5'h04, 32'h0, 0, 32'h87654321, 0, 1'b0);
    checkOutput("b2b_accept_spacing", 32'(accept_cyc - first_acc), 32'd4);

    $display("[TB] randomized transfers");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 6), $urandom,
                    $urandom_range(0, 3), 1'($urandom));
    end

    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("final_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("final_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
